// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frames a continuous zero-padded sample stream into NFFT-point
// FFT frames, one frame per range bin, BIN_COUNT bins per pulse.
//
// Optional feature macro: FRAME_CHECK_EN. When defined, a data_valid drop
// mid-frame forces a zero-valued fft_last, returns to IDLE and sets the
// sticky frame_err output. When undefined, the frame_err port does not exist
// and the counters simply hold across data_valid gaps.
//
// Ports:
//   clk, rst            single clock, asynchronous active-high reset
//   data_in             BIT_WIDTH signed sample, padded zeros included
//   data_valid          sample valid (no backpressure)
//   BIN_COUNT           range bins per pulse (1..16, 0 treated as 1), latched at frame start
//   fft_ready           FFT core accepts data
//   fft_re / fft_im     sign-extended sample / constant zero imaginary part
//   fft_valid, fft_last sample valid / last point of frame (1-cycle latency)
//   bin_index           range bin of the current frame
//   pulse_done          one-cycle pulse after the last point of the last bin
//   overflow            sticky: a sample was presented while fft_ready was low
//   frame_err           (FRAME_CHECK_EN only) sticky: frame truncated by a gap
module fft_frame_ctrl #(
  parameter int unsigned BIT_WIDTH = 14,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned NFFT      = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_WIDTH-1:0] data_in,
  input  logic                 data_valid,
  input  logic [4:0]           BIN_COUNT,
  input  logic                 fft_ready,
  output logic [OUT_WIDTH-1:0] fft_re,
  output logic [OUT_WIDTH-1:0] fft_im,
  output logic                 fft_valid,
  output logic                 fft_last,
  output logic [3:0]           bin_index,
  output logic                 pulse_done,
`ifdef FRAME_CHECK_EN
  output logic                 frame_err,
`endif
  output logic                 overflow
);

  localparam int unsigned PW = $clog2(NFFT) + 1;

  // DONE emits pulse_done once; WAIT swallows trailing samples until data_valid drops
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_WAIT} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        point_q, point_d;
  logic [3:0]           bin_q, bin_d;
  logic [4:0]           bins_q, bins_d;
  logic [OUT_WIDTH-1:0] fft_re_q, fft_re_d;
  logic                 fft_valid_q, fft_valid_d;
  logic                 fft_last_q, fft_last_d;
  logic [3:0]           bin_index_q, bin_index_d;
  logic                 pulse_done_q, pulse_done_d;
  logic                 overflow_q, overflow_d;
  logic                 frame_err_q, frame_err_d;

  logic [4:0]           bin_count_eff;
  logic [4:0]           bins_now;
  logic                 accept;
  logic                 last_pt;
  logic                 last_bin;

  // Next-state and output computation
  always_comb begin
    state_d      = state_q;
    point_d      = point_q;
    bin_d        = bin_q;
    bins_d       = bins_q;
    fft_re_d     = '0;
    fft_valid_d  = 1'b0;
    fft_last_d   = 1'b0;
    bin_index_d  = bin_index_q;
    pulse_done_d = 1'b0;
    overflow_d   = overflow_q;
    frame_err_d  = frame_err_q;

    // 0 means one bin; values above 16 cannot be indexed by a 4-bit bin counter
    if (BIN_COUNT == 5'd0)       bin_count_eff = 5'd1;
    else if (BIN_COUNT > 5'd16)  bin_count_eff = 5'd16;
    else                         bin_count_eff = BIN_COUNT;

    // The frame-start sample must see the value being latched this cycle
    bins_now = (state_q == S_IDLE) ? bin_count_eff : bins_q;
    accept   = data_valid && (state_q == S_IDLE || state_q == S_RUN);
    last_pt  = (point_q == PW'(NFFT - 1));
    last_bin = ({1'b0, bin_q} == 5'(bins_now - 5'd1));

    case (state_q)
      S_IDLE: begin
        bins_d = bin_count_eff;
        if (data_valid) state_d = S_RUN;
      end
      S_RUN: begin
`ifdef FRAME_CHECK_EN
        // Truncate a gapped frame with a zero sample so the core still sees a boundary
        if (!data_valid && point_q != '0) begin
          fft_valid_d = 1'b1;
          fft_last_d  = 1'b1;
          bin_index_d = bin_q;
          frame_err_d = 1'b1;
          point_d     = '0;
          bin_d       = '0;
          state_d     = S_IDLE;
        end
`endif
      end
      S_DONE: begin
        pulse_done_d = 1'b1;
        bin_index_d  = '0;
        state_d      = data_valid ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        if (!data_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      fft_valid_d = 1'b1;
      fft_re_d    = OUT_WIDTH'($signed(data_in));
      fft_last_d  = last_pt;
      bin_index_d = bin_q;
      // Sample is still counted when lost, keeping frame alignment
      if (!fft_ready) overflow_d = 1'b1;
      if (last_pt) begin
        point_d = '0;
        if (last_bin) begin
          bin_d   = '0;
          state_d = S_DONE;
        end else begin
          bin_d = 4'(bin_q + 4'd1);
        end
      end else begin
        point_d = PW'(point_q + PW'(1));
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      point_q      <= '0;
      bin_q        <= '0;
      bins_q       <= 5'd1;
      fft_re_q     <= '0;
      fft_valid_q  <= 1'b0;
      fft_last_q   <= 1'b0;
      bin_index_q  <= '0;
      pulse_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      point_q      <= point_d;
      bin_q        <= bin_d;
      bins_q       <= bins_d;
      fft_re_q     <= fft_re_d;
      fft_valid_q  <= fft_valid_d;
      fft_last_q   <= fft_last_d;
      bin_index_q  <= bin_index_d;
      pulse_done_q <= pulse_done_d;
      overflow_q   <= overflow_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign fft_re     = fft_re_q;
  assign fft_im     = '0;
  assign fft_valid  = fft_valid_q;
  assign fft_last   = fft_last_q;
  assign bin_index  = bin_index_q;
  assign pulse_done = pulse_done_q;
  assign overflow   = overflow_q;
`ifdef FRAME_CHECK_EN
  assign frame_err  = frame_err_q;
`else
  logic unused_frame_err;
  assign unused_frame_err = frame_err_q ^ frame_err_d;
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl: expected output beats are queued as
// stimulus is driven and popped by a monitor whenever fft_valid is seen.
module tb_fft_frame_ctrl;

  localparam int unsigned BW = 14;
  localparam int unsigned OW = 16;
  localparam int unsigned N  = 1024;

  logic          clk;
  logic          rst;
  logic [BW-1:0] data_in;
  logic          data_valid;
  logic [4:0]    BIN_COUNT;
  logic          fft_ready;
  logic [OW-1:0] fft_re;
  logic [OW-1:0] fft_im;
  logic          fft_valid;
  logic          fft_last;
  logic [3:0]    bin_index;
  logic          pulse_done;
  logic          overflow;
`ifdef FRAME_CHECK_EN
  logic          frame_err;
`endif

  typedef struct packed {
    logic [OW-1:0] re;
    logic          last;
    logic [3:0]    bin;
  } exp_t;

  exp_t exp_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  fft_frame_ctrl #(.BIT_WIDTH(BW), .OUT_WIDTH(OW), .NFFT(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .BIN_COUNT  (BIN_COUNT),
    .fft_ready  (fft_ready),
    .fft_re     (fft_re),
    .fft_im     (fft_im),
    .fft_valid  (fft_valid),
    .fft_last   (fft_last),
    .bin_index  (bin_index),
    .pulse_done (pulse_done),
`ifdef FRAME_CHECK_EN
    .frame_err  (frame_err),
`endif
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [BW-1:0] d, input logic last, input logic [3:0] bin);
    exp_t e;
    e.re   = {{(OW-BW){d[BW-1]}}, d};
    e.last = last;
    e.bin  = bin;
    return e;
  endfunction

  task automatic drive(input logic dv, input logic [BW-1:0] d, input logic rdy);
    @(negedge clk);
    data_valid = dv;
    data_in    = d;
    fft_ready  = rdy;
  endtask

  // Scoreboard monitor: every output beat must match the oldest queued expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (fft_valid === 1'b1) begin
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_valid: got re=%h last=%b bin=%0d, required no output",
                 fft_re, fft_last, bin_index);
      end else begin
        e = exp_q.pop_front();
        if ({fft_re, fft_last, bin_index} !== {e.re, e.last, e.bin} || fft_im !== '0)
          $display("FAIL sb_beat: got re=%h im=%h last=%b bin=%0d, required re=%h im=0 last=%b bin=%0d",
                   fft_re, fft_im, fft_last, bin_index, e.re, e.last, e.bin);
        else
          pass_cnt++;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; data_valid = 1'b0; data_in = '0; fft_ready = 1'b1; BIN_COUNT = 5'd1;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({fft_re, fft_im, fft_valid, fft_last, bin_index, pulse_done, overflow} !== '0)
      $display("FAIL reset_outputs: got re=%h im=%h v=%b l=%b bin=%0d pd=%b ovf=%b, required all 0",
               fft_re, fft_im, fft_valid, fft_last, bin_index, pulse_done, overflow);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_three_bins();
    logic [BW-1:0] d;
    BIN_COUNT = 5'd3;
    for (int i = 0; i < 3 * N; i++) begin
      d = BW'($urandom);
      drive(1'b1, d, 1'b1);
      exp_q.push_back(mk(d, (i % N) == N - 1, 4'(i / N)));
    end
    drive(1'b0, '0, 1'b1);
    chk_cnt++;
    if (fft_last !== 1'b1 || pulse_done !== 1'b0)
      $display("FAIL three_bins_final_last: got last=%b pd=%b, required last=1 pd=0", fft_last, pulse_done);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (pulse_done !== 1'b1 || fft_valid !== 1'b0)
      $display("FAIL three_bins_pulse: got pd=%b v=%b, required pd=1 v=0", pulse_done, fft_valid);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (pulse_done !== 1'b0 || bin_index !== 4'd0)
      $display("FAIL three_bins_after_pulse: got pd=%b bin=%0d, required pd=0 bin=0", pulse_done, bin_index);
    else pass_cnt++;
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL three_bins_drain: got %0d pending, required 0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_sign_ext();
    logic [BW-1:0] d;
    BIN_COUNT = 5'd1;
    for (int i = 0; i < N; i++) begin
      d = (i == 0) ? 14'h2000 : (i == 1) ? 14'h1FFF : (i == 2) ? 14'h3FFF : BW'($urandom);
      drive(1'b1, d, 1'b1);
      exp_q.push_back(mk(d, i == N - 1, 4'd0));
      if (i == 1) begin
        chk_cnt++;
        if (fft_re !== 16'hE000 || fft_im !== 16'h0000 || fft_valid !== 1'b1)
          $display("FAIL sign_ext_2000: got re=%h im=%h v=%b, required re=e000 im=0000 v=1",
                   fft_re, fft_im, fft_valid);
        else pass_cnt++;
      end
    end
    repeat (4) drive(1'b0, '0, 1'b1);
    chk_cnt++;
    if (fft_re !== '0) $display("FAIL sign_ext_idle_zero: got re=%h, required 0000", fft_re);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [BW-1:0] d;
    BIN_COUNT = 5'd1;
    for (int i = 0; i < N; i++) begin
      d = BW'($urandom);
      drive(1'b1, d, (i == 499) ? 1'b0 : 1'b1);
      exp_q.push_back(mk(d, i == N - 1, 4'd0));
      if (i == 499 || i == 500) begin
        chk_cnt++;
        if (overflow !== (i == 500))
          $display("FAIL overflow_at_%0d: got %b, required %b", i, overflow, i == 500);
        else pass_cnt++;
      end
    end
    repeat (4) drive(1'b0, '0, 1'b1);
    chk_cnt++;
    if (overflow !== 1'b1) $display("FAIL overflow_sticky: got %b, required 1", overflow);
    else pass_cnt++;
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL overflow_drain: got %0d pending, required 0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    logic [BW-1:0] d;
    BIN_COUNT = 5'd2;
    for (int i = 0; i < N + 699; i++) begin
      d = BW'($urandom_range(1, 8191));
      drive(1'b1, d, 1'b1);
      exp_q.push_back(mk(d, (i % N) == N - 1, 4'(i / N)));
    end
    @(negedge clk);
    #1;
    rst = 1'b1;
    data_valid = 1'b0;
    #1;
    chk_cnt++;
    if ({fft_re, fft_im, fft_valid, fft_last, bin_index, pulse_done, overflow} !== '0)
      $display("FAIL reset_mid_frame: got re=%h v=%b l=%b bin=%0d pd=%b ovf=%b, required all 0",
               fft_re, fft_valid, fft_last, bin_index, pulse_done, overflow);
    else pass_cnt++;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    BIN_COUNT = 5'd1;
    for (int i = 0; i < N; i++) begin
      d = BW'($urandom);
      drive(1'b1, d, 1'b1);
      exp_q.push_back(mk(d, i == N - 1, 4'd0));
      if (i == 1) begin
        chk_cnt++;
        if (fft_valid !== 1'b1 || bin_index !== 4'd0)
          $display("FAIL restart_bin0: got v=%b bin=%0d, required v=1 bin=0", fft_valid, bin_index);
        else pass_cnt++;
      end
    end
    repeat (4) drive(1'b0, '0, 1'b1);
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL restart_drain: got %0d pending, required 0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_gap();
    logic [BW-1:0] d;
    BIN_COUNT = 5'd1;
    for (int i = 0; i < 300; i++) begin
      d = BW'($urandom);
      drive(1'b1, d, 1'b1);
      exp_q.push_back(mk(d, 1'b0, 4'd0));
    end
`ifdef FRAME_CHECK_EN
    exp_q.push_back(mk('0, 1'b1, 4'd0));
`endif
    for (int g = 0; g < 5; g++) begin
      drive(1'b0, '0, 1'b1);
      if (g == 2) begin
        chk_cnt++;
        if (fft_valid !== 1'b0)
          $display("FAIL gap_no_valid: got v=%b, required 0", fft_valid);
        else pass_cnt++;
      end
    end
`ifdef FRAME_CHECK_EN
    chk_cnt++;
    if (frame_err !== 1'b1) $display("FAIL gap_frame_err: got %b, required 1", frame_err);
    else pass_cnt++;
    for (int i = 0; i < N; i++) begin
      d = BW'($urandom);
      drive(1'b1, d, 1'b1);
      exp_q.push_back(mk(d, i == N - 1, 4'd0));
    end
`else
    for (int i = 300; i < N; i++) begin
      d = BW'($urandom);
      drive(1'b1, d, 1'b1);
      exp_q.push_back(mk(d, i == N - 1, 4'd0));
    end
`endif
    repeat (4) drive(1'b0, '0, 1'b1);
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL gap_drain: got %0d pending, required 0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_bin_zero();
    logic [BW-1:0] d;
    int pulses;
    int valids;
    pulses = 0;
    valids = 0;
    BIN_COUNT = 5'd0;
    for (int i = 0; i < N + 6; i++) begin
      d = BW'($urandom);
      drive(1'b1, d, 1'b1);
      if (i < N) exp_q.push_back(mk(d, i == N - 1, 4'd0));
      if (pulse_done === 1'b1) pulses++;
      if (fft_valid === 1'b1) valids++;
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, '0, 1'b1);
      if (pulse_done === 1'b1) pulses++;
      if (fft_valid === 1'b1) valids++;
    end
    chk_cnt++;
    if (pulses != 1) $display("FAIL bin_zero_pulse_count: got %0d, required 1", pulses);
    else pass_cnt++;
    chk_cnt++;
    if (valids != N) $display("FAIL bin_zero_valid_count: got %0d, required %0d", valids, N);
    else pass_cnt++;
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL bin_zero_drain: got %0d pending, required 0", exp_q.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_three_bins();
    test_sign_ext();
    test_overflow();
    test_reset_mid_frame();
    test_gap();
    test_bin_zero();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
